// File: rtl/fir_output_stage.sv
// FIR output stage: rounds and saturates the accumulated sum, then buffers
// the conditioned samples in a small FIFO feeding a valid/ready consumer.
// Sticky flags record saturation events and samples lost to a full buffer.
module fir_output_stage #(
  parameter int N     = 32,
  parameter int M     = 16,
  parameter int SHIFT = 15,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] y_in,
  input  logic         y_valid,
  output logic         in_ready,
  output logic [M-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         sat_flag,
  output logic         drop_flag,
  input  logic         clr_flags
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [N:0] ROUND = (SHIFT > 0) ? ((N+1)'(1) << RS) : '0;

  logic signed [N:0] sum_ext;
  logic signed [N:0] shifted;
  logic              fits;
  logic [M-1:0]      cond_data;
  logic              cond_sat;

  logic [M-1:0]      p_data;
  logic              p_valid;
  logic              p_sat;

  logic [M-1:0]      mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;

  logic              accept;
  logic              drop;
  logic              push;
  logic              pop;

  // Round half up, shift down, and clamp to the signed output range
  always_comb begin
    sum_ext   = $signed({y_in[N-1], y_in}) + ROUND;
    shifted   = sum_ext >>> SHIFT;
    fits      = (&shifted[N:M-1]) || !(|shifted[N:M-1]);
    cond_sat  = !fits;
    cond_data = shifted[M-1:0];
    if (!fits) begin
      cond_data = shifted[N] ? {1'b1, {(M-1){1'b0}}} : {1'b0, {(M-1){1'b1}}};
    end
  end

  // Handshake decode; ready counts the sample already in flight so a write never meets a full FIFO
  always_comb begin
    in_ready  = (int'(count) + int'(p_valid)) < DEPTH;
    accept    = y_valid && in_ready;
    drop      = y_valid && !in_ready;
    out_valid = (count != '0);
    out_data  = out_valid ? mem[rd_ptr] : '0;
    push      = p_valid;
    pop       = out_valid && out_ready;
  end

  // Conditioning register holding one sample between capture and FIFO write
  always_ff @(posedge clk) begin
    if (rst) begin
      p_valid <= 1'b0;
      p_sat   <= 1'b0;
      p_data  <= '0;
    end else begin
      p_valid <= accept;
      if (accept) begin
        p_data <= cond_data;
        p_sat  <= cond_sat;
      end
    end
  end

  // FIFO storage write; contents need no reset because count gates the output
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= p_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky status flags; a new event on the clearing edge keeps the flag set
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_flag  <= 1'b0;
      drop_flag <= 1'b0;
    end else begin
      sat_flag  <= (sat_flag && !clr_flags) || (p_valid && p_sat);
      drop_flag <= (drop_flag && !clr_flags) || drop;
    end
  end

endmodule

// File: tb/tb_fir_output_stage.sv
// Testbench for fir_output_stage: directed test-plan steps plus a random
// phase, all compared against a queue-based reference model every cycle.
module tb_fir_output_stage;

  localparam int N     = 32;
  localparam int M     = 16;
  localparam int SHIFT = 15;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] y_in = '0;
  logic         y_valid = 1'b0;
  logic         in_ready;
  logic [M-1:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         sat_flag;
  logic         drop_flag;
  logic         clr_flags = 1'b0;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [M-1:0] q[$];
  bit           m_pv = 1'b0;
  bit           m_ps = 1'b0;
  logic [M-1:0] m_pd = '0;
  bit           m_sat = 1'b0;
  bit           m_drop = 1'b0;

  fir_output_stage #(.N(N), .M(M), .SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .y_in      (y_in),
    .y_valid   (y_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sat_flag  (sat_flag),
    .drop_flag (drop_flag),
    .clr_flags (clr_flags)
  );

  // free-running clock
  always #5 clk = ~clk;

  // plain-arithmetic rounding, shifting and clamping of one sum
  function automatic logic [M-1:0] condition(input logic [N-1:0] y, output bit sat);
    longint v;
    longint r;
    v = longint'($signed(y)) + (longint'(1) <<< (SHIFT - 1));
    r = v >>> SHIFT;
    sat = 1'b0;
    if (r > 32767) begin
      sat = 1'b1;
      return 16'h7FFF;
    end else if (r < -32768) begin
      sat = 1'b1;
      return 16'h8000;
    end
    return r[M-1:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_output();
    logic [M-1:0] exp_data;
    bit           exp_valid;
    exp_valid = (q.size() != 0);
    exp_data  = exp_valid ? q[0] : '0;
    check("out_valid", out_valid, exp_valid);
    check("out_data", out_data, exp_data);
    check("in_ready", in_ready, (q.size() + int'(m_pv)) < DEPTH);
    check("sat_flag", sat_flag, m_sat);
    check("drop_flag", drop_flag, m_drop);
  endtask

  // advance model and DUT by one clock with the currently driven inputs
  task automatic step();
    bit ready_m;
    bit ns;
    bit nd;
    if (rst) begin
      q.delete();
      m_pv   = 1'b0;
      m_sat  = 1'b0;
      m_drop = 1'b0;
    end else begin
      ready_m = (q.size() + int'(m_pv)) < DEPTH;
      ns = (m_sat && !clr_flags) || (m_pv && m_ps);
      nd = (m_drop && !clr_flags) || (y_valid && !ready_m);
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (m_pv) q.push_back(m_pd);
      m_pv = y_valid && ready_m;
      if (m_pv) m_pd = condition(y_in, m_ps);
      m_sat  = ns;
      m_drop = nd;
    end
    @(posedge clk);
    #1;
    check_output();
  endtask

  // one isolated sample through an empty stage, checked against a fixed value
  task automatic single_sample(input logic [N-1:0] y, input logic [M-1:0] exp, input string tag);
    out_ready = 1'b0;
    y_valid = 1'b1; y_in = y;
    step();
    y_valid = 1'b0;
    step();
    check(tag, out_data, exp);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    // reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("reset_valid", out_valid, 1'b0);
    check("reset_ready", in_ready, 1'b1);
    check("reset_data", out_data, 16'h0000);

    // rounding boundaries
    single_sample(32'h00004000, 16'h0001, "round_pos_half");
    single_sample(32'h00003FFF, 16'h0000, "round_pos_below");
    single_sample(32'hFFFFC000, 16'h0000, "round_neg_half");
    single_sample(32'hFFFFBFFF, 16'hFFFF, "round_neg_below");
    check("round_no_sat", sat_flag, 1'b0);

    // saturation and flag clearing
    single_sample(32'h7FFFFFFF, 16'h7FFF, "sat_pos");
    check("sat_pos_flag", sat_flag, 1'b1);
    clr_flags = 1'b1; step(); clr_flags = 1'b0;
    check("sat_cleared", sat_flag, 1'b0);
    single_sample(32'h80000000, 16'h8000, "sat_neg");
    check("sat_neg_flag", sat_flag, 1'b1);
    clr_flags = 1'b1; step(); clr_flags = 1'b0;
    y_valid = 1'b1; y_in = 32'h7FFFFFFF; step();
    y_valid = 1'b0; clr_flags = 1'b1; step(); clr_flags = 1'b0;
    check("sat_set_wins", sat_flag, 1'b1);
    out_ready = 1'b1; step(); step();
    clr_flags = 1'b1; step(); clr_flags = 1'b0;

    // latency and streaming
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      y_valid = (i < 8);
      y_in = N'(i) << SHIFT;
      step();
      if (i == 0) check("stream_latency", out_valid, 1'b0);
      if (i >= 1 && i <= 8) begin
        check("stream_valid", out_valid, 1'b1);
        check("stream_data", out_data, M'(i - 1));
      end
    end
    y_valid = 1'b0;

    // backpressure and drop
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      y_valid = 1'b1; y_in = N'(i) << SHIFT;
      step();
      if (i == 3) check("bp_ready_before", in_ready, 1'b1);
      if (i == 4) check("bp_ready_fall", in_ready, 1'b0);
    end
    y_valid = 1'b0;
    check("bp_drop", drop_flag, 1'b1);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("bp_order", out_data, M'(i));
      step();
    end
    check("bp_drained", out_valid, 1'b0);
    clr_flags = 1'b1; step(); clr_flags = 1'b0;

    // push and pop together near full, across pointer wrap
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      y_valid = 1'b1; y_in = N'(100 + i) << SHIFT; step();
    end
    y_valid = 1'b0; step();
    out_ready = 1'b1;
    for (int i = 0; i < 3 * DEPTH + 2; i++) begin
      y_valid = 1'b1; y_in = N'(200 + i) << SHIFT; step();
    end
    y_valid = 1'b0;
    check("full_no_drop", drop_flag, 1'b0);
    for (int i = 0; i < 5; i++) step();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      y_valid   = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      clr_flags = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0:       y_in = $urandom;
        1:       y_in = N'($urandom_range(0, 65535)) - 32'd32768;
        2:       y_in = {{9{1'b0}}, 23'($urandom)} - 32'h0040_0000;
        default: y_in = ($urandom_range(0, 1) != 0) ? 32'h7FFF_0000 : 32'h8000_FFFF;
      endcase
      step();
    end
    y_valid = 1'b0; clr_flags = 1'b0;

    // reset in the middle of buffered traffic
    out_ready = 1'b0;
    clr_flags = 1'b1; step(); clr_flags = 1'b0;
    while (q.size() != 0) begin out_ready = 1'b1; step(); end
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      y_valid = 1'b1; y_in = N'(50 + i) << SHIFT; step();
    end
    rst = 1'b1; out_ready = 1'b1; y_in = 32'h7FFFFFFF; step();
    rst = 1'b0; y_valid = 1'b0; out_ready = 1'b0;
    check("rst_mid_valid", out_valid, 1'b0);
    check("rst_mid_ready", in_ready, 1'b1);
    check("rst_mid_flags", {sat_flag, drop_flag}, 2'b00);
    y_valid = 1'b1; y_in = N'(9) << SHIFT; step();
    y_valid = 1'b0; step();
    check("rst_mid_first", out_data, 16'h0009);
    out_ready = 1'b1; step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fir_output_stage.md
# fir_output_stage

Output conditioning stage placed directly after the last tapped-delay tap of the FIR chain. It captures the chain's accumulated sum on each sample strobe. It then rescales the sum with round-half-up, saturates it to the output width, and buffers the result in a small FIFO that drives a valid/ready stream to the consumer. Sticky status flags report saturation and samples dropped while the FIFO was full.

## Interface
- N, 32: width of the accumulated FIR sum (signed two's complement).
- M, 16: output sample width (signed); M <= N.
- SHIFT, 15: right-shift applied to the sum (coefficient fraction bits); 0 <= SHIFT < N.
- DEPTH, 4: FIFO depth, power of two, >= 2.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- y_in  in  N  accumulated sum from the final tap.
- y_valid  in  1  sample strobe; same signal that drives the chain's ena.
- in_ready  out  1  stage can accept a sample this cycle; upstream may use it to gate ena.
- out_data  out  M  head-of-FIFO sample.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts out_data.
- sat_flag  out  1  sticky: at least one accepted sample saturated.
- drop_flag  out  1  sticky: at least one sample was dropped.
- clr_flags  in  1  clears both sticky flags.

## Operation
- Stage 1 (conditioning register), on an edge with y_valid && in_ready:
  - compute the sign-extended N+1-bit sum s = y_in + (SHIFT>0 ? 2^(SHIFT-1) : 0);
  - compute r = s >>> SHIFT (arithmetic shift);
  - saturate r to [-2^(M-1), 2^(M-1)-1];
  - register the result in p_data with p_valid=1, and register p_sat = (clamping occurred).
- Otherwise p_valid is cleared on the next edge.
- Stage 2: when p_valid=1, p_data is written into the FIFO on the following edge. sat_flag is set on that same edge if p_sat=1.
- Ready rule: in_ready = (count + p_valid) < DEPTH, using registered values only.
  - A pop in the same cycle does not raise in_ready; this is a deliberately conservative rule.
  - The rule guarantees that a stage-2 write never meets a full FIFO.
- Drop: when y_valid=1 and in_ready=0, the sample is discarded and drop_flag is set on that edge.
- Pop: out_valid && out_ready removes the head entry. Output order is strict FIFO order.
- Simultaneous push and pop: count is unchanged and both operations take effect.
- Pointers wrap modulo DEPTH.
- clr_flags clears both flags. If a set condition occurs on the same edge as clr_flags, the set wins.
- Reset clears p_valid, the FIFO pointers and count, and both flags. Any in-flight or buffered samples are discarded. FIFO storage contents are don't-care.

## Timing
- Reset values:
  - out_valid=0, out_data=0 while empty;
  - in_ready=1;
  - sat_flag=0, drop_flag=0.
- Latency from an accepted y_valid at edge t:
  - the sample sits in p_data after edge t;
  - it is in the FIFO after edge t+1;
  - out_valid=1 in the cycle after edge t+1, if the FIFO was empty.
- Throughput: one sample per clock while out_ready=1.
- out_valid and out_data are driven from FIFO state, with no combinational path from out_ready.
- in_ready is registered-state only, with no combinational path from y_valid or out_ready.
- Output is held stable while out_valid=1 and out_ready=0.
- The rst pulse dominates all other inputs in its cycle.

## Test plan
- Rounding (N=32, M=16, SHIFT=15): y_in=0x00004000 -> out_data=0x0001; 0x00003FFF -> 0x0000; 0xFFFFC000 -> 0x0000; 0xFFFFBFFF -> 0xFFFF; sat_flag stays 0 throughout.
- Saturation:
  - y_in=0x7FFFFFFF -> 0x7FFF with sat_flag=1;
  - then clr_flags for one cycle -> sat_flag=0;
  - then y_in=0x80000000 -> 0x8000 with sat_flag=1;
  - clr_flags on the same edge as a saturating write -> sat_flag=1.
- Latency and streaming: out_ready=1, y_valid high for 8 cycles with y_in=k<<15, k=0..7.
  - First out_valid appears 2 edges after the first strobe.
  - Outputs are 0..7, back-to-back, with no gaps.
- Backpressure and drop: out_ready=0, five consecutive strobes with values 1..5 (<<15).
  - in_ready falls after the 4th strobe; the 5th is dropped and drop_flag=1.
  - Then out_ready=1 -> outputs 1,2,3,4 and out_valid falls.
- Simultaneous push/pop at full: hold the FIFO at count=DEPTH-1 while popping every cycle and strobing every cycle.
  - No drops occur and order is preserved across pointer wrap (run at least 3*DEPTH samples).
- Reset mid-operation: with 3 entries buffered and one in p_data, assert rst for 1 cycle.
  - Next cycle: out_valid=0, in_ready=1, flags=0.
  - The next accepted sample is the first one output.
